// File: rtl/alu2_sequencer.sv
// Command-side sequencer for the opcode-driven multiply-accumulate ALU.
// Optional macro ALU2_SEQ_DELTA_EN: report per-batch delta instead of raw accumulator.
`timescale 1ns/1ps
module alu2_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    a_reset_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_a,
   input  logic [DATA_WIDTH-1:0]   s_b,
   input  logic                    s_last,
   output logic [3:0]              alu_opcode,
   output logic [DATA_WIDTH-1:0]   alu_data_out,
   input  logic [DATA_WIDTH-1:0]   alu_data_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [2*DATA_WIDTH-1:0] m_result,
   output logic [CNT_WIDTH-1:0]    m_count,
   output logic                    busy
);
   localparam int RW = 2 * DATA_WIDTH;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_REGA  = 4'd1;
   localparam logic [3:0] OP_REGB  = 4'd2;
   localparam logic [3:0] OP_MULT  = 4'd3;
   localparam logic [3:0] OP_ACC   = 4'd4;
   localparam logic [3:0] OP_MSB   = 4'd5;
   localparam logic [3:0] OP_LSB   = 4'd6;
   localparam logic [3:0] OP_RESET = 4'd7;

   typedef enum logic [3:0] {
      IDLE, LOAD_A, LOAD_B, MUL, ACC, RD_MSB, RD_LSB, RD_WAIT, CLR, OUT
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic                  last_q;
   logic [CNT_WIDTH-1:0]  pair_cnt;
   logic [DATA_WIDTH-1:0] hi_q;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [RW-1:0]         raw;
`ifdef ALU2_SEQ_DELTA_EN
   logic [RW-1:0]         prev_q;
`endif

   assign raw     = {hi_q, lo_q};
   assign s_ready = (state == IDLE);
   assign busy    = (state != IDLE);

   // Opcode and data registers always carry the value for the state being entered.
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         state        <= IDLE;
         alu_opcode   <= OP_NOP;
         alu_data_out <= '0;
         a_q          <= '0;
         b_q          <= '0;
         last_q       <= 1'b0;
         pair_cnt     <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         m_valid      <= 1'b0;
         m_result     <= '0;
         m_count      <= '0;
`ifdef ALU2_SEQ_DELTA_EN
         prev_q       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  a_q          <= s_a;
                  b_q          <= s_b;
                  last_q       <= s_last;
                  pair_cnt     <= pair_cnt + 1'b1;
                  state        <= LOAD_A;
                  alu_opcode   <= OP_REGA;
                  alu_data_out <= s_a;
               end
            end
            LOAD_A: begin
               state        <= LOAD_B;
               alu_opcode   <= OP_REGB;
               alu_data_out <= b_q;
            end
            LOAD_B: begin
               state        <= MUL;
               alu_opcode   <= OP_MULT;
               alu_data_out <= '0;
            end
            MUL: begin
               state      <= ACC;
               alu_opcode <= OP_ACC;
            end
            ACC: begin
               if (last_q) begin
                  state      <= RD_MSB;
                  alu_opcode <= OP_MSB;
               end else begin
                  state      <= IDLE;
                  alu_opcode <= OP_NOP;
               end
            end
            RD_MSB: begin
               state      <= RD_LSB;
               alu_opcode <= OP_LSB;
            end
            // The ALU output lags its opcode by one edge, so each half lands a cycle late.
            RD_LSB: begin
               hi_q       <= alu_data_in;
               state      <= RD_WAIT;
               alu_opcode <= OP_NOP;
            end
            RD_WAIT: begin
               lo_q       <= alu_data_in;
               state      <= CLR;
               alu_opcode <= OP_RESET;
            end
            CLR: begin
`ifdef ALU2_SEQ_DELTA_EN
               m_result <= raw - prev_q;
               prev_q   <= raw;
`else
               m_result <= raw;
`endif
               m_count    <= pair_cnt;
               pair_cnt   <= '0;
               m_valid    <= 1'b1;
               state      <= OUT;
               alu_opcode <= OP_NOP;
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               alu_opcode <= OP_NOP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu2_sequencer.sv
// Directed bench for alu2_sequencer driving a behavioural model of the MAC ALU.
`timescale 1ns/1ps
module tb_alu2_sequencer;
   logic        clk = 1'b0;
   logic        a_reset_n;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_a;
   logic [7:0]  s_b;
   logic        s_last;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_data_out;
   logic [7:0]  alu_data_in;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_result;
   logic [7:0]  m_count;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu2_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .a_reset_n(a_reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .alu_opcode(alu_opcode), .alu_data_out(alu_data_out), .alu_data_in(alu_data_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_count(m_count),
      .busy(busy)
   );

   // ALU model: one opcode per edge, registered output bus, accumulator never cleared by opcode.
   logic [7:0]  alu_ra, alu_rb;
   logic [15:0] alu_prod, alu_acc;
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         alu_ra <= '0; alu_rb <= '0; alu_prod <= '0; alu_acc <= '0; alu_data_in <= '0;
      end else begin
         case (alu_opcode)
            4'd1: alu_ra <= alu_data_out;
            4'd2: alu_rb <= alu_data_out;
            4'd3: alu_prod <= {8'd0, alu_ra} * {8'd0, alu_rb};
            4'd4: alu_acc <= alu_acc + alu_prod;
            4'd5: alu_data_in <= alu_acc[15:8];
            4'd6: alu_data_in <= alu_acc[7:0];
            4'd7: alu_data_in <= '0;
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      a_reset_n = 1'b0;
      @(negedge clk);
      a_reset_n = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge of the first LOAD_A cycle.
   task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
      int n = 0;
      s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [15:0] exp_res, input logic [7:0] exp_cnt);
      int n = 0;
      while (!m_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
      chk({tag, "_result"}, {16'd0, m_result}, {16'd0, exp_res});
      chk({tag, "_count"}, {24'd0, m_count}, {24'd0, exp_cnt});
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, m_valid}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   logic [3:0] seq [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd7};
   logic [15:0] exp_t3, exp_t4;

   initial begin
`ifdef ALU2_SEQ_DELTA_EN
      exp_t3 = 16'h000A;
      exp_t4 = 16'h0002;
`else
      exp_t3 = 16'h0016;
      exp_t4 = 16'hFC04;
`endif
      a_reset_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
      #12;
      chk("rst_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("rst_data", {24'd0, alu_data_out}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_result", {16'd0, m_result}, 32'd0);
      chk("rst_m_count", {24'd0, m_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      a_reset_n = 1'b1;
      @(negedge clk);

      // Test 1: single pair, full opcode sequence.
      send_pair(8'd3, 8'd4, 1'b1);
      chk("t1_data_a", {24'd0, alu_data_out}, 32'd3);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_op%0d", i), {28'd0, alu_opcode}, {28'd0, seq[i]});
         if (i == 1) chk("t1_data_b", {24'd0, alu_data_out}, 32'd4);
         @(negedge clk);
      end
      chk("t1_valid_after_clr", {31'd0, m_valid}, 32'd1);
      get_result("t1", 16'h000C, 8'd1);

      // Test 3: follow-on batch shows cumulative or delta result.
      send_pair(8'd2, 8'd5, 1'b1);
      get_result("t3", exp_t3, 8'd1);

      // Test 2: two maximal pairs after a fresh reset, accumulator wraps.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         send_pair(8'd255, 8'd255, p == 1);
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("t2_busy_p%0d_c%0d", p, c), {31'd0, s_ready}, 32'd0);
            @(negedge clk);
         end
         if (p == 0) chk("t2_ready_again", {31'd0, s_ready}, 32'd1);
      end
      get_result("t2", 16'hFC02, 8'd2);

      // Test 4: back-pressure in OUT, ignored s_valid pulses.
      send_pair(8'd1, 8'd2, 1'b1);
      while (!m_valid) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         s_valid = c[0]; s_a = 8'd9; s_b = 8'd9; s_last = 1'b1;
         chk($sformatf("t4_valid_c%0d", c), {31'd0, m_valid}, 32'd1);
         chk($sformatf("t4_result_c%0d", c), {16'd0, m_result}, {16'd0, exp_t4});
         chk($sformatf("t4_count_c%0d", c), {24'd0, m_count}, 32'd1);
         chk($sformatf("t4_s_ready_c%0d", c), {31'd0, s_ready}, 32'd0);
         chk($sformatf("t4_opcode_c%0d", c), {28'd0, alu_opcode}, 32'd0);
         @(negedge clk);
      end
      s_valid = 1'b0;
      get_result("t4", exp_t4, 8'd1);
      @(negedge clk);
      chk("t4_no_ghost_pair", {28'd0, alu_opcode}, 32'd0);

      // Test 5: asynchronous reset during MUL.
      send_pair(8'd9, 8'd9, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("t5_in_mul", {28'd0, alu_opcode}, 32'd3);
      a_reset_n = 1'b0;
      #1;
      chk("t5_rst_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      a_reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (m_valid) chk("t5_partial_emitted", 32'd1, 32'd0);
      end
      send_pair(8'd1, 8'd1, 1'b1);
      get_result("t5", 16'h0001, 8'd1);

      // Test 6: 256-pair batch wraps the pair counter.
      do_reset();
      for (int p = 0; p < 256; p++) send_pair(8'd1, 8'd1, p == 255);
      get_result("t6", 16'h0100, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
